// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   GLYPH_TAB : 16-entry glyph table, active-high {g,f,e,d,c,b,a}, entry n at [n]
//   SEG_BLANK : all segments off
//   clog2     : ceiling log2, used to size counters
package seg_scan_driver_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index 0 is the rightmost element, so entry n is GLYPH_TAB[n].
  // 0-9 are decimal digits; A,b,C,d,E,F follow.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_driver_decode.sv
// Nibble to 7-segment glyph decoder (combinational, active-high).
//   nibble   : digit value 0..15
//   hex_mode : 1 = show A..F for 10..15, 0 = blank for 10..15
//   glyph    : {g,f,e,d,c,b,a}, 1 = segment on
module seg_scan_driver_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_TAB[nibble];
    if (!hex_mode && (nibble > 4'd9)) glyph = SEG_BLANK;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver for N_DIGITS digits with frame-coherent
// shadow loading, per-digit enable / decimal point / blink, leading-zero
// suppression and an anti-ghosting blank interval at the start of every slot.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture digit_val/digit_en/dp_en/blink_en/lz_en into pending
//   digit_val  : nibble i = value of digit i (digit 0 rightmost)
//   digit_en   : 1 = digit shown
//   dp_en      : 1 = decimal point lit
//   blink_en   : 1 = digit blinks
//   lz_en      : 1 = suppress leading zeros
//   seg_an     : one-hot digit select (polarity per ACTIVE_LOW)
//   seg_cat    : {dp,g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
//   frame_tick : 1-clk pulse when the slot index wraps to 0
// Handshake: load is a single-cycle strobe with no back-pressure; every cycle it
// is high the inputs are captured, and the last capture before a frame start wins.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int CLK_DIV      = 6250,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 0,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digit_val,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   dp_en,
  input  logic [N_DIGITS-1:0]   blink_en,
  input  logic                  lz_en,
  output logic [N_DIGITS-1:0]   seg_an,
  output logic [7:0]            seg_cat,
  output logic                  frame_tick
);

  localparam int IDX_W = (clog2(N_DIGITS) < 1) ? 1 : clog2(N_DIGITS);
  localparam int DIV_W = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
  localparam int BLK_W = clog2(BLINK_FRAMES) + 1;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic             POL       = (ACTIVE_LOW != 0);

  // Scan timing
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_end;
  logic             frame_start;

  // Blink
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_ph;

  // Pending (written by load) and shadow (displayed) register sets
  logic [4*N_DIGITS-1:0] pd_val, sh_val;
  logic [N_DIGITS-1:0]   pd_en, sh_en;
  logic [N_DIGITS-1:0]   pd_dp, sh_dp;
  logic [N_DIGITS-1:0]   pd_blink, sh_blink;
  logic                  pd_lz, sh_lz;
  logic                  pend_vld;
  // Cleared by reset, set on the first shadow load; until then the display is
  // completely dark, anodes included.
  logic                  sh_vld;

  // Current-digit decode
  logic [N_DIGITS-1:0] lz_blank;
  logic                above_clear;
  logic [3:0]          cur_val;
  logic                cur_en, cur_dp, cur_blink, cur_lz;
  logic [6:0]          glyph;
  logic                en_blank;
  logic                lit;
  logic [N_DIGITS-1:0] an_next;
  logic [7:0]          cat_next;

  assign slot_end    = (div_cnt == DIV_LAST);
  assign frame_start = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  // Shadow only ever changes at a frame start, so one frame never mixes data
  // from two loads. A load on the frame-start edge goes straight to shadow and
  // supersedes anything still waiting in pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pd_val   <= '0;
      pd_en    <= '0;
      pd_dp    <= '0;
      pd_blink <= '0;
      pd_lz    <= 1'b0;
      pend_vld <= 1'b0;
      sh_val   <= '0;
      sh_en    <= '0;
      sh_dp    <= '0;
      sh_blink <= '0;
      sh_lz    <= 1'b0;
      sh_vld   <= 1'b0;
    end else if (frame_start && load) begin
      sh_val   <= digit_val;
      sh_en    <= digit_en;
      sh_dp    <= dp_en;
      sh_blink <= blink_en;
      sh_lz    <= lz_en;
      sh_vld   <= 1'b1;
      pend_vld <= 1'b0;
    end else if (load) begin
      pd_val   <= digit_val;
      pd_en    <= digit_en;
      pd_dp    <= dp_en;
      pd_blink <= blink_en;
      pd_lz    <= lz_en;
      pend_vld <= 1'b1;
    end else if (frame_start && pend_vld) begin
      sh_val   <= pd_val;
      sh_en    <= pd_en;
      sh_dp    <= pd_dp;
      sh_blink <= pd_blink;
      sh_lz    <= pd_lz;
      sh_vld   <= 1'b1;
      pend_vld <= 1'b0;
    end
  end

  // Leading-zero mask, walking down from the most significant digit. A digit
  // stops the suppression only if it is enabled and non-zero; digit 0 is never
  // suppressed.
  always_comb begin
    lz_blank    = '0;
    above_clear = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if ((i > 0) && sh_lz && above_clear && (sh_val[4*i +: 4] == 4'd0))
        lz_blank[i] = 1'b1;
      if (sh_en[i] && (sh_val[4*i +: 4] != 4'd0))
        above_clear = 1'b0;
    end
  end

  always_comb begin
    cur_val   = '0;
    cur_en    = 1'b0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_val   = sh_val[4*i +: 4];
        cur_en    = sh_en[i];
        cur_dp    = sh_dp[i];
        cur_blink = sh_blink[i];
        cur_lz    = lz_blank[i];
      end
    end
  end

  seg_scan_driver_decode u_decode (
    .nibble   (cur_val),
    .hex_mode (HEX_MODE != 0),
    .glyph    (glyph)
  );

  // Enable and blink blank the whole digit; value and leading-zero blanking
  // leave the decimal point alone.
  assign en_blank = !cur_en || (cur_blink && blink_ph);
  assign lit      = sh_vld && (div_cnt >= BLANK_END);

  always_comb begin
    an_next  = '0;
    cat_next = '0;
    if (lit) begin
      for (int i = 0; i < N_DIGITS; i++) an_next[i] = (idx == IDX_W'(i));
      cat_next[6:0] = (en_blank || cur_lz) ? SEG_BLANK : glyph;
      cat_next[7]   = cur_dp && !en_blank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_an     <= {N_DIGITS{POL}};
      seg_cat    <= {8{POL}};
      frame_tick <= 1'b0;
    end else begin
      seg_an     <= an_next ^ {N_DIGITS{POL}};
      seg_cat    <= cat_next ^ {8{POL}};
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (decimal and hex glyph mode) share
// one stimulus. A table of display vectors with hand-derived per-digit cathode
// patterns drives the main checks; short hand sequences cover the double load,
// coincident load, blink and asynchronous reset cases.
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int BF    = 2;
  localparam int FRAME = N * DIV;
  localparam int NV    = 12;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        load = 1'b0;
  logic [15:0] digit_val = '0;
  logic [3:0]  digit_en = '0, dp_en = '0, blink_en = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  an0, an1;
  logic [7:0]  cat0, cat1;
  logic        tick0, tick1;

  seg_scan_driver #(.N_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYC(BLANK),
                    .BLINK_FRAMES(BF), .HEX_MODE(0), .ACTIVE_LOW(1)) dut0 (
    .clk(clk), .rst(rst), .load(load), .digit_val(digit_val), .digit_en(digit_en),
    .dp_en(dp_en), .blink_en(blink_en), .lz_en(lz_en),
    .seg_an(an0), .seg_cat(cat0), .frame_tick(tick0));

  seg_scan_driver #(.N_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYC(BLANK),
                    .BLINK_FRAMES(BF), .HEX_MODE(1), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .digit_val(digit_val), .digit_en(digit_en),
    .dp_en(dp_en), .blink_en(blink_en), .lz_en(lz_en),
    .seg_an(an1), .seg_cat(cat1), .frame_tick(tick1));

  // Vector: inputs plus expected active-low cathodes {d3,d2,d1,d0} for
  // HEX_MODE=0 (e0) and HEX_MODE=1 (e1), in the visible blink phase.
  typedef struct {
    logic [15:0] val;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic [3:0]  blink;
    logic        lz;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vt [NV];

  // Scoreboard: {an[3:0], cat_hex0[7:0], cat_hex1[7:0], tick}
  logic [20:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  // Reference state: which vector is in shadow (-1 = nothing loaded yet),
  // pending vector, and frame count since reset (for blink phase).
  int sh_i   = -1;
  int pend_i = 0;
  bit pv     = 1'b0;
  int k      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic drive_vec(input int ix);
    digit_val = vt[ix].val;
    digit_en  = vt[ix].en;
    dp_en     = vt[ix].dp;
    blink_en  = vt[ix].blink;
    lz_en     = vt[ix].lz;
  endtask

  function automatic logic [7:0] exp_digit(input int i, input bit hex, input int ph);
    logic [31:0] e;
    if (sh_i < 0) return 8'hFF;
    e = hex ? vt[sh_i].e1 : vt[sh_i].e0;
    if (vt[sh_i].blink[i] && (ph == 1)) return 8'hFF;
    return e[8*i +: 8];
  endfunction

  // Counts negedges until frame_tick; 200 is the give-up bound.
  task automatic wait_tick(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (tick0 === 1'b1) break;
    end
    k++;
  endtask

  // Called on the negedge of a frame_tick cycle. Checks the following 32
  // cycles (ending on the next frame_tick) and optionally pulses load at
  // frame cycles ca and cb (0 = unused; FRAME-1 = coincident with frame start).
  task automatic run_frame(input int ca, input int ia, input int cb, input int ib);
    int p, d, i, ph, coinc;
    bit lit;
    logic [3:0]  oh, ea;
    logic [7:0]  e0, e1;
    logic [20:0] x;
    ph = (k / BF) % 2;
    coinc = -1;
    for (int c = 1; c <= FRAME; c++) begin
      p   = c - 1;
      d   = p % DIV;
      i   = p / DIV;
      lit = (d >= BLANK) && (sh_i >= 0);
      oh  = 4'b0001 << i;
      ea  = lit ? ~oh : 4'hF;
      e0  = lit ? exp_digit(i, 1'b0, ph) : 8'hFF;
      e1  = lit ? exp_digit(i, 1'b1, ph) : 8'hFF;
      exp_q.push_back({ea, e0, e1, (c == FRAME)});
    end
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk($sformatf("queue_empty c%0d", c), 32'd0, 32'd1);
      end else begin
        x = exp_q.pop_front();
        chk($sformatf("an0 k%0d c%0d", k, c), 32'(an0), 32'(x[20:17]));
        chk($sformatf("an1 k%0d c%0d", k, c), 32'(an1), 32'(x[20:17]));
        chk($sformatf("cat_dec k%0d c%0d", k, c), 32'(cat0), 32'(x[16:9]));
        chk($sformatf("cat_hex k%0d c%0d", k, c), 32'(cat1), 32'(x[8:1]));
        chk($sformatf("tick0 k%0d c%0d", k, c), 32'(tick0), 32'(x[0]));
        chk($sformatf("tick1 k%0d c%0d", k, c), 32'(tick1), 32'(x[0]));
      end
      load = 1'b0;
      if (c == ca || c == cb) begin
        drive_vec((c == ca) ? ia : ib);
        load = 1'b1;
        if (c == FRAME - 1) coinc = (c == ca) ? ia : ib;
        else begin
          pend_i = (c == ca) ? ia : ib;
          pv     = 1'b1;
        end
      end
    end
    // The frame start happened on the edge before this negedge.
    if (coinc >= 0) begin
      sh_i = coinc;
      pv   = 1'b0;
    end else if (pv) begin
      sh_i = pend_i;
      pv   = 1'b0;
    end
    k++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an0"}, 32'(an0), 32'hF);
    chk({tag, "_an1"}, 32'(an1), 32'hF);
    chk({tag, "_cat0"}, 32'(cat0), 32'hFF);
    chk({tag, "_cat1"}, 32'(cat1), 32'hFF);
    chk({tag, "_tick"}, 32'(tick0), 32'h0);
  endtask

  task automatic release_and_sync(input string tag);
    int cyc;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    sh_i   = -1;
    pv     = 1'b0;
    k      = 0;
    exp_q.delete();
    wait_tick(cyc);
    chk({tag, "_first_tick_cycles"}, 32'(cyc), 32'd32);
  endtask

  initial begin
    vt[0]  = '{16'h1234, 4'hF, 4'h0, 4'h0, 1'b0, 32'hF9A4B099, 32'hF9A4B099};
    vt[1]  = '{16'h00A5, 4'hF, 4'h0, 4'h0, 1'b1, 32'hFFFFFF92, 32'hFFFF8892};
    vt[2]  = '{16'h2222, 4'hF, 4'h0, 4'h0, 1'b0, 32'hA4A4A4A4, 32'hA4A4A4A4};
    vt[3]  = '{16'h1111, 4'hF, 4'h0, 4'h0, 1'b0, 32'hF9F9F9F9, 32'hF9F9F9F9};
    vt[4]  = '{16'h0000, 4'hF, 4'h0, 4'h0, 1'b1, 32'hFFFFFFC0, 32'hFFFFFFC0};
    vt[5]  = '{16'h0000, 4'hF, 4'h0, 4'h0, 1'b0, 32'hC0C0C0C0, 32'hC0C0C0C0};
    vt[6]  = '{16'h0F07, 4'hB, 4'h6, 4'h0, 1'b1, 32'hFFFF7FF8, 32'hFFFF7FF8};
    vt[7]  = '{16'hC09E, 4'hF, 4'h9, 4'h0, 1'b1, 32'h7FC0907F, 32'h46C09006};
    vt[8]  = '{16'h0B0D, 4'hF, 4'h0, 4'h0, 1'b1, 32'hFFFFC0FF, 32'hFF83C0A1};
    vt[9]  = '{16'h5678, 4'hF, 4'hF, 4'h0, 1'b0, 32'h12027800, 32'h12027800};
    vt[10] = '{16'h8888, 4'h0, 4'hF, 4'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[11] = '{16'h1234, 4'hF, 4'h2, 4'h1, 1'b0, 32'hF9A43099, 32'hF9A43099};

    // Power-on reset
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    release_and_sync("por");
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 0, 0);

    // Reset in the middle of a slot
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midslot");
    release_and_sync("midslot");
    run_frame(0, 0, 0, 0);

    // Table: alternate mid-frame and frame-start-coincident loads; each frame
    // checks the previous vector still holds while the new one is pending.
    for (int v = 0; v < NV; v++) begin
      run_frame((v % 2 == 1) ? FRAME - 1 : 10, v, 0, 0);
    end
    run_frame(0, 0, 0, 0);

    // Two loads in one frame: only the later one appears next frame
    run_frame(5, 3, 20, 2);
    run_frame(0, 0, 0, 0);

    // Mid-frame load overridden by a coincident load; pending must not resurface
    run_frame(8, 0, FRAME - 1, 9);
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 0, 0);

    // Blink on digit 0, decimal point on digit 1
    run_frame(10, 11, 0, 0);
    for (int f = 0; f < 5; f++) run_frame(0, 0, 0, 0);

    // Asynchronous reset while digit 0 is lit
    repeat (4) @(negedge clk);
    chk("prelit_an0", 32'(an0), 32'hE);
    #1 rst = 1'b1;
    #1 check_reset_outputs("async");
    release_and_sync("async");
    run_frame(10, 0, 0, 0);
    run_frame(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
